// File: rtl/micro_ucr_hash_pkg.sv
// Shared constants and FSM encoding for the micro_ucr_hash engine.
package micro_ucr_hash_pkg;

  localparam logic [7:0] H0_INIT = 8'h01;
  localparam logic [7:0] H1_INIT = 8'h89;
  localparam logic [7:0] H2_INIT = 8'hFE;

  localparam logic [7:0] K_LO           = 8'h99;
  localparam logic [7:0] K_HI           = 8'hA1;
  localparam logic [4:0] K_SWITCH_ROUND = 5'd16;

  localparam int N_MSG_BYTES = 16;
  localparam int N_ROUNDS    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_ROUND,
    ST_FINAL
  } state_t;

endpackage

// File: rtl/micro_ucr_hash_round.sv
// One compression round over the three working registers.
module micro_ucr_hash_round
  import micro_ucr_hash_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] w,
  input  logic [4:0] idx,
  output logic [7:0] a_next,
  output logic [7:0] b_next,
  output logic [7:0] c_next
);

  logic       early;
  logic [7:0] k;
  logic [7:0] x;

  // Rounds up to and including the switch round mix a with b; later rounds mix a with c.
  assign early  = (idx <= K_SWITCH_ROUND);
  assign k      = early ? K_LO : K_HI;
  assign x      = early ? (a ^ b) : (a ^ c);

  assign a_next = b ^ c;
  assign b_next = c << 4;
  assign c_next = x + k + w;

endmodule

// File: rtl/micro_ucr_hash.sv
// Sequential micro_ucr_hash engine: expand 16 message bytes to 32, then 32 rounds.
module micro_ucr_hash
  import micro_ucr_hash_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         hash_init,
  input  logic         valid,
  input  logic [127:0] block_in,
  output logic [23:0]  hash,
  output logic         hash_ready
);

  state_t     state;
  state_t     state_next;
  logic [7:0] w_mem [N_ROUNDS];
  logic [4:0] cnt;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic [7:0] a_next;
  logic [7:0] b_next;
  logic [7:0] c_next;
  logic [7:0] w_exp;
  logic       start;
  logic       cnt_last;

  assign start    = hash_init && valid;
  assign cnt_last = (cnt == 5'd31);

  micro_ucr_hash_round u_round (
    .a      (a),
    .b      (b),
    .c      (c),
    .w      (w_mem[cnt]),
    .idx    (cnt),
    .a_next (a_next),
    .b_next (b_next),
    .c_next (c_next)
  );

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    w_exp      = w_mem[cnt - 5'd3] | (w_mem[cnt - 5'd9] ^ w_mem[cnt - 5'd14]);
    case (state)
      ST_IDLE:   if (start)    state_next = ST_EXPAND;
      ST_EXPAND: if (cnt_last) state_next = ST_ROUND;
      ST_ROUND:  if (cnt_last) state_next = ST_FINAL;
      ST_FINAL:                state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      hash       <= '0;
      hash_ready <= 1'b0;
      // NOTE: the message array is small and must read as zero after reset, so it is cleared here.
      for (int i = 0; i < N_ROUNDS; i++) w_mem[i] <= '0;
    end else begin
      state      <= state_next;
      hash_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < N_MSG_BYTES; i++) w_mem[i] <= block_in[8*i +: 8];
            a   <= H0_INIT;
            b   <= H1_INIT;
            c   <= H2_INIT;
            cnt <= 5'd16;
          end
        end
        ST_EXPAND: begin
          w_mem[cnt] <= w_exp;
          cnt        <= cnt + 5'd1;   // wraps 31 -> 0 for the first round
        end
        ST_ROUND: begin
          a   <= a_next;
          b   <= b_next;
          c   <= c_next;
          cnt <= cnt + 5'd1;
        end
        ST_FINAL: begin
          hash       <= {H0_INIT + a, H1_INIT + b, H2_INIT + c};
          hash_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_ucr_hash.sv
// Self-checking bench for micro_ucr_hash: directed scenarios plus a randomized nonce sweep.
module tb_micro_ucr_hash;

  logic         clk = 1'b0;
  logic         reset;
  logic         hash_init;
  logic         valid;
  logic [127:0] block_in;
  logic [23:0]  hash;
  logic         hash_ready;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] last_hash;

  micro_ucr_hash dut (
    .clk        (clk),
    .reset      (reset),
    .hash_init  (hash_init),
    .valid      (valid),
    .block_in   (block_in),
    .hash       (hash),
    .hash_ready (hash_ready)
  );

  always #5 clk = ~clk;

  // Reference digest computed directly from the algorithm description.
  function automatic logic [23:0] ref_hash(input logic [127:0] blk);
    byte unsigned w [32];
    byte unsigned a, b, c, x, k, na;
    for (int i = 0; i < 16; i++) w[i] = blk[8*i +: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int i = 0; i < 32; i++) begin
      if (i <= 16) begin k = 8'h99; x = a ^ b; end
      else         begin k = 8'hA1; x = a ^ c; end
      na = b ^ c;
      b  = byte'((c * 16) % 256);
      c  = byte'((int'(x) + int'(k) + int'(w[i])) % 256);
      a  = na;
    end
    return {8'(8'h01 + a), 8'(8'h89 + b), 8'(8'hFE + c)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watch n cycles with no start; hash_ready must stay low.
  task automatic idle_watch(input string tag, input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (hash_ready === 1'b1) pulses++;
    end
    check({tag, " no stray pulse"}, pulses, 0);
  endtask

  // Start a hash on the next edge (E0) and follow it through E49.
  task automatic run_hash(input logic [127:0] blk, input string tag,
                          input bit scramble, input bit inject);
    logic [23:0] exp;
    int          early = 0;
    exp       = ref_hash(blk);
    hash_init = 1'b1;
    valid     = 1'b1;
    block_in  = blk;
    tick();                                   // E0
    hash_init = 1'b0;
    valid     = 1'b0;
    if (scramble) block_in = {$urandom, $urandom, $urandom, $urandom};
    check({tag, " ready low on start edge"}, 32'(hash_ready), 32'd0);
    for (int cyc = 1; cyc <= 48; cyc++) begin
      if (inject && cyc == 20) begin
        hash_init = 1'b1;
        valid     = 1'b1;
        block_in  = ~blk;
      end
      tick();
      hash_init = 1'b0;
      valid     = 1'b0;
      if (hash_ready === 1'b1) early++;
    end
    check({tag, " no early pulse"}, early, 0);
    check({tag, " hash held during run"}, 32'(hash), 32'(last_hash));
    tick();                                   // E49
    check({tag, " ready at E49"}, 32'(hash_ready), 32'd1);
    check({tag, " digest"}, 32'(hash), 32'(exp));
    last_hash = exp;
  endtask

  initial begin
    logic [127:0] blk;
    logic [7:0]   hdr [12];
    logic [95:0]  rnd_hdr;

    reset     = 1'b1;
    hash_init = 1'b0;
    valid     = 1'b0;
    block_in  = '0;
    last_hash = '0;
    repeat (3) tick();
    check("reset hash", 32'(hash), 32'd0);
    check("reset ready", 32'(hash_ready), 32'd0);
    reset = 1'b0;
    tick();

    // hash_init without valid must not start anything
    hash_init = 1'b1;
    valid     = 1'b0;
    block_in  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    hash_init = 1'b0;
    idle_watch("init without valid", 60);
    check("init without valid hash", 32'(hash), 32'd0);

    // zero block against the known digest
    run_hash('0, "zero block", 1'b0, 1'b0);
    check("zero block known value", 32'(hash), 32'h707957);
    idle_watch("zero block after", 5);

    // header block, nonce 0
    hdr = '{8'h61, 8'h69, 8'h63, 8'h70, 8'h21, 8'h00,
            8'h00, 8'h03, 8'h17, 8'h08, 8'h00, 8'hF3};
    blk = '0;
    for (int i = 0; i < 12; i++) blk[8*i +: 8] = hdr[i];
    run_hash(blk, "header block", 1'b0, 1'b0);
    idle_watch("header block after", 5);

    // block_in changes right after the start edge
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_hash(blk, "input stability", 1'b1, 1'b0);
    idle_watch("input stability after", 5);

    // start request in the middle of a computation is ignored
    blk = {$urandom, $urandom, $urandom, $urandom};
    run_hash(blk, "ignored mid start", 1'b0, 1'b1);
    idle_watch("ignored mid start after", 60);

    // reset during round 10 (edge E27) aborts the computation
    hash_init = 1'b1;
    valid     = 1'b1;
    block_in  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    hash_init = 1'b0;
    valid     = 1'b0;
    repeat (26) tick();
    reset = 1'b1;
    tick();
    check("mid reset hash", 32'(hash), 32'd0);
    check("mid reset ready", 32'(hash_ready), 32'd0);
    reset     = 1'b0;
    last_hash = '0;
    idle_watch("mid reset after", 60);
    run_hash('0, "zero after reset", 1'b0, 1'b0);
    check("zero after reset known value", 32'(hash), 32'h707957);

    // back-to-back nonce sweep over a random header, starts on E50
    rnd_hdr = {$urandom, $urandom, $urandom};
    for (int n = 0; n < 256; n++) begin
      blk = {32'(n), rnd_hdr};
      run_hash(blk, $sformatf("nonce %0d", n), 1'b0, 1'b0);
    end
    idle_watch("sweep after", 10);
    check("sweep hash holds", 32'(hash), 32'(last_hash));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
